// File: rtl/modmul_pkg.sv
// Shared constants and helpers for the signed Barrett modular multiplier.
package modmul_pkg;

    localparam int unsigned Q     = 249857;
    localparam int unsigned QW    = 18;
    localparam int unsigned K     = 40;
    localparam int unsigned LANES = 1;
    localparam int unsigned HALFQ = (Q - 1) / 2;

    // Per-beat output mode encoding
    localparam logic LAZY     = 1'b1;
    localparam logic DILIGENT = 1'b0;

    // Barrett constant M = round(2^k / q)
    function automatic longint unsigned barrett_m(input longint unsigned q, input int unsigned k);
        return ((64'd1 << k) + (q >> 1)) / q;
    endfunction

endpackage

// File: rtl/modmul_signed_pipe_lane.sv
// barrett_lane_s: one lane of the signed Barrett multiplier, stages S1-S4 under a shared enable.
module barrett_lane_s
    import modmul_pkg::*;
#(
    parameter int unsigned Q  = modmul_pkg::Q,
    parameter int unsigned QW = modmul_pkg::QW,
    parameter int unsigned K  = modmul_pkg::K
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic signed [QW-1:0] a_i,
    input  logic signed [QW-1:0] b_i,
    input  logic                 lazy_i,
    output logic signed [QW-1:0] c_o
);

    localparam int unsigned ZW  = 2 * QW;
    localparam int unsigned MW  = K - $clog2(Q) + 2;
    localparam int unsigned TW  = ZW + MW + 1;
    localparam int unsigned RW  = ZW + 2;
    localparam int unsigned QTW = TW - K;

    localparam logic signed [MW-1:0] MS   = MW'(barrett_m(64'(Q), K));
    localparam logic signed [TW-1:0] RND  = {{(TW - K){1'b0}}, 1'b1, {(K - 1){1'b0}}};
    localparam logic signed [RW-1:0] QS   = RW'(Q);
    localparam logic signed [RW-1:0] HQ   = RW'((Q - 1) / 2);
    localparam logic signed [RW-1:0] CMAX = RW'((longint'(1) << (QW - 1)) - 1);
    localparam logic signed [RW-1:0] CMIN = -CMAX - 1;

    logic signed [ZW-1:0]  z_d, z_q, z2_q;
    logic signed [TW-1:0]  t_d, t_q;
    logic signed [QTW-1:0] qt;
    logic signed [RW-1:0]  r_d, r_q;
    logic signed [RW-1:0]  rc;
    logic signed [QW-1:0]  c_d, c_q;

    // Next-state for all four stages; widths keep every product exact up to the S3 subtraction
    always_comb begin
        z_d = ZW'(a_i) * ZW'(b_i);
        t_d = TW'(z_q) * TW'(MS);
        qt  = QTW'((t_q + RND) >>> K);
        r_d = RW'(z2_q) - RW'(qt) * QS;
        rc  = r_q;
        if (lazy_i == LAZY) begin
            // Only pull r back into the representable QW-bit range
            if (r_q > CMAX) begin
                rc = r_q - QS;
            end else if (r_q < CMIN) begin
                rc = r_q + QS;
            end
        end else begin
            if (r_q > HQ) begin
                rc = r_q - QS;
            end else if (r_q < -HQ) begin
                rc = r_q + QS;
            end
        end
        c_d = QW'(rc);
    end

    // Pipeline registers, frozen together while the output is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q  <= '0;
            z2_q <= '0;
            t_q  <= '0;
            r_q  <= '0;
            c_q  <= '0;
        end else if (en_i) begin
            z_q  <= z_d;
            z2_q <= z_q;
            t_q  <= t_d;
            r_q  <= r_d;
            c_q  <= c_d;
        end
    end

    assign c_o = c_q;

endmodule

// File: rtl/modmul_signed_pipe.sv
// modmul_signed_pipe: LANES-wide 4-stage signed Barrett modular multiplier with valid/ready.
module modmul_signed_pipe
    import modmul_pkg::*;
#(
    parameter int unsigned Q     = modmul_pkg::Q,
    parameter int unsigned QW    = modmul_pkg::QW,
    parameter int unsigned LANES = modmul_pkg::LANES,
    parameter int unsigned K     = modmul_pkg::K
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*QW-1:0]   inA,
    input  logic [LANES*QW-1:0]   inB,
    input  logic                  in_lazy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*QW-1:0]   outC
);

    localparam logic signed [QW-1:0] HQ = QW'((Q - 1) / 2);

    logic       en;
    logic [3:0] vld_d, vld_q;
    logic [2:0] lazy_d, lazy_q;

    // Whole pipeline moves only when the output slot is free or being drained
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_q[3];

    // Valid and mode flags shift alongside the data
    always_comb begin
        vld_d  = {vld_q[2:0], in_valid};
        lazy_d = {lazy_q[1:0], in_lazy};
    end

    // Control shift chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            lazy_q <= '0;
        end else if (en) begin
            vld_q  <= vld_d;
            lazy_q <= lazy_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        barrett_lane_s #(
            .Q  (Q),
            .QW (QW),
            .K  (K)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   (en),
            .a_i    (inA[i*QW +: QW]),
            .b_i    (inB[i*QW +: QW]),
            .lazy_i (lazy_q[2]),
            .c_o    (outC[i*QW +: QW])
        );
    end

    function automatic logic in_range(input logic signed [QW-1:0] x);
        return (x <= HQ) && (x >= -HQ);
    endfunction

    // Flag accepted operands outside [-HALFQ, HALFQ]
    always_ff @(posedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            for (int i = 0; i < int'(LANES); i++) begin
                assert (in_range(inA[i*QW +: QW]) && in_range(inB[i*QW +: QW]))
                else $error("modmul_signed_pipe: operand out of range on lane %0d", i);
            end
        end
    end

endmodule

// File: tb/tb_modmul_signed_pipe.sv
// Randomised self-checking bench for modmul_signed_pipe against a centred-mod reference.
module tb_modmul_signed_pipe;

    localparam int Q1 = 249857;
    localparam int H1 = 124928;
    localparam int Q2 = 7681;
    localparam int H2 = 3840;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_lazy, out_valid, out_ready;
    logic [17:0] inA, inB, outC;

    logic        in_valid2, in_ready2, in_lazy2, out_valid2, out_ready2;
    logic [55:0] inA2, inB2, outC2;

    int n_checks = 0;
    int n_errors = 0;
    bit rand_ready = 1'b0;

    typedef struct {
        longint a;
        longint b;
        bit     lazy;
    } beat_t;
    beat_t exp_q[$];

    int a2v[4];
    int b2v[4];

    always #5 clk = ~clk;

    modmul_signed_pipe #(.Q(249857), .QW(18), .LANES(1), .K(40)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inA       (inA),
        .inB       (inB),
        .in_lazy   (in_lazy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .outC      (outC)
    );

    modmul_signed_pipe #(.Q(7681), .QW(14), .LANES(4), .K(40)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .inA       (inA2),
        .inB       (inB2),
        .in_lazy   (in_lazy2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .outC      (outC2)
    );

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Centred residue in [-(q-1)/2, (q-1)/2]
    function automatic longint cmod(input longint z, input longint q);
        longint m = z % q;
        if (m > (q - 1) / 2) m -= q;
        else if (m < -((q - 1) / 2)) m += q;
        return m;
    endfunction

    function automatic bit lazy_ok(input longint got, input longint gold, input longint q);
        return ((got - gold) % q == 0) && (got < q) && (got > -q);
    endfunction

    function automatic int rnd_op(input int h);
        int unsigned s = $urandom_range(0, 7);
        if (s == 0) return h;
        if (s == 1) return -h;
        return int'($urandom_range(0, 2 * h)) - h;
    endfunction

    // Scoreboard and stall checks for the single-lane instance
    bit          stall_prev = 1'b0;
    logic [17:0] held;
    always @(negedge clk) begin
        beat_t  bt;
        longint got;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_data", outC, held);
            end
            if (out_valid && !out_ready) begin
                check_eq("stall_in_ready", in_ready, 0);
                held       = outC;
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
            if (out_valid && out_ready) begin
                check_eq("spurious_out", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    bt  = exp_q.pop_front();
                    got = longint'($signed(outC));
                    if (bt.lazy) check_eq("lazy_res", lazy_ok(got, cmod(bt.a * bt.b, Q1), Q1), 1);
                    else         check_eq("dil_res", got, cmod(bt.a * bt.b, Q1));
                end
            end
            if (in_valid && in_ready) begin
                bt.a    = longint'($signed(inA));
                bt.b    = longint'($signed(inB));
                bt.lazy = in_lazy;
                exp_q.push_back(bt);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Present one beat and hold it until accepted
    task automatic send1(input int a, input int b, input bit lz);
        bit acc = 1'b0;
        inA      = 18'(a);
        inB      = 18'(b);
        in_lazy  = lz;
        in_valid = 1'b1;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) check_eq("accept_timeout", acc, 1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int w = 0; w < 50 && (exp_q.size() != 0 || out_valid); w++) begin
            @(posedge clk);
            #1;
        end
        check_eq("drain", exp_q.size(), 0);
    endtask

    // Single beat with latency and an exact expected value (diligent)
    task automatic dir1(input string tag, input int a, input int b, input longint exp);
        int n = 1;
        @(posedge clk);
        #1;
        inA      = 18'(a);
        inB      = 18'(b);
        in_lazy  = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        while (!out_valid && n < 12) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({tag, "_lat"}, n, 4);
        check_eq(tag, longint'($signed(outC)), exp);
    endtask

    // One 4-lane beat into the small-modulus instance, checked lane by lane
    task automatic beat2(input string tag, input bit lz);
        int     n = 1;
        longint got;
        longint gold;
        for (int i = 0; i < 4; i++) begin
            inA2[i*14 +: 14] = 14'(a2v[i]);
            inB2[i*14 +: 14] = 14'(b2v[i]);
        end
        in_lazy2  = lz;
        in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        while (!out_valid2 && n < 12) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({tag, "_lat"}, n, 4);
        for (int i = 0; i < 4; i++) begin
            got  = longint'($signed(outC2[i*14 +: 14]));
            gold = cmod(longint'(a2v[i]) * longint'(b2v[i]), Q2);
            if (lz) check_eq({tag, "_lazy"}, lazy_ok(got, gold, Q2), 1);
            else    check_eq(tag, got, gold);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_lazy    = 1'b0;
        inA        = '0;
        inB        = '0;
        out_ready  = 1'b0;
        in_valid2  = 1'b0;
        in_lazy2   = 1'b0;
        inA2       = '0;
        inB2       = '0;
        out_ready2 = 1'b1;
        #12;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_outc", outC, 0);
        check_eq("rst_out_valid2", out_valid2, 0);
        #10;
        rst_n = 1'b1;
        #1;
        check_eq("in_ready_after_rst", in_ready, 1);

        out_ready = 1'b1;
        dir1("basic_hq_sq", 124928, 124928, -62464);
        dir1("basic_2_hq", 2, 124928, -1);
        dir1("basic_zero", 0, -5, 0);
        dir1("sign_neg", -124928, 124928, 62464);
        dir1("sign_m1", -1, -1, 1);

        // Stream 8 beats with alternating mode while out_ready drops for 3 cycles
        @(posedge clk);
        #1;
        fork
            begin
                for (int n = 0; n < 8; n++) send1(rnd_op(H1), rnd_op(H1), n[0]);
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Random traffic with bubbles, random backpressure and mixed modes
        rand_ready = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            send1(rnd_op(H1), rnd_op(H1), 1'($urandom_range(0, 1)));
        end
        in_valid   = 1'b0;
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        drain();

        // Reset with beats in flight
        out_ready = 1'b1;
        for (int n = 0; n < 5; n++) send1(rnd_op(H1), rnd_op(H1), 1'b0);
        in_valid = 1'b0;
        check_eq("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_outc", outC, 0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            check_eq("post_rst_valid", out_valid, 0);
        end

        // Four-lane small-modulus instance
        a2v = '{3840, -3840, 2, 0};
        b2v = '{3840, 3840, 3840, 5};
        beat2("p4_dir", 1'b0);
        check_eq("p4_3840sq", longint'($signed(outC2[13:0])), -1920);
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) begin
                a2v[i] = rnd_op(H2);
                b2v[i] = rnd_op(H2);
            end
            beat2("p4_rand", n[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
